// File: rtl/serial_run_pkg.sv
// Shared state encoding and default sizing for serial_run_tx and serial_run_tracker.
package serial_run_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    STUFF = 2'd2
  } state_e;

  localparam int unsigned DEF_WIDTH   = 8;
  localparam int unsigned DEF_RUN_LEN = 3;
  localparam int unsigned RUN_CNT_W   = $clog2(DEF_RUN_LEN + 1);

endpackage

// File: rtl/serial_run_tx_if.sv
// Word handshake in, serial bit stream out, for serial_run_tx.
interface serial_run_tx_if #(
  parameter int unsigned WIDTH = serial_run_pkg::DEF_WIDTH
) ();

  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             a;
  logic             a_valid;
  logic             run_flag;
  logic             stuffed;

  modport master (
    output din, din_valid,
    input  din_ready, a, a_valid, run_flag, stuffed
  );

  modport slave (
    input  din, din_valid,
    output din_ready, a, a_valid, run_flag, stuffed
  );

endinterface

// File: rtl/serial_run_tracker.sv
// Tracks runs of equal valid bits; run_flag is aligned with the bit presented on the
// previous cycle's bit_in/bit_valid, and run_cnt is the run length including that bit.
module serial_run_tracker
  import serial_run_pkg::*;
#(
  parameter  int unsigned RUN_LEN = DEF_RUN_LEN,
  localparam int unsigned CNT_W   = $clog2(RUN_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_valid,
  input  logic             bit_in,
  output logic             run_flag,
  output logic [CNT_W-1:0] run_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RUN_LEN);

  logic             last_bit_q, last_bit_d;
  logic             valid_q, valid_d;
  logic             run_flag_q, run_flag_d;
  logic [CNT_W-1:0] run_cnt_q, run_cnt_d;

  always_comb begin
    last_bit_d = last_bit_q;
    valid_d    = bit_valid;
    run_cnt_d  = '0;
    run_flag_d = 1'b0;
    if (bit_valid) begin
      last_bit_d = bit_in;
      if (!valid_q || (bit_in != last_bit_q)) begin
        run_cnt_d = CNT_W'(1);
      end else if (run_cnt_q == CNT_MAX) begin
        run_cnt_d = CNT_MAX;
      end else begin
        run_cnt_d = run_cnt_q + CNT_W'(1);
      end
      run_flag_d = (run_cnt_d == CNT_MAX);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      last_bit_q <= 1'b0;
      valid_q    <= 1'b0;
      run_cnt_q  <= '0;
      run_flag_q <= 1'b0;
    end else begin
      last_bit_q <= last_bit_d;
      valid_q    <= valid_d;
      run_cnt_q  <= run_cnt_d;
      run_flag_q <= run_flag_d;
    end
  end

  assign run_flag = run_flag_q;
  assign run_cnt  = run_cnt_q;

endmodule

// File: rtl/serial_run_tx.sv
// Parallel-to-serial transmitter, MSB first, flagging completed runs of RUN_LEN bits.
// Defining SERIAL_RUN_TX_STUFF_EN adds bit stuffing so no run ever reaches RUN_LEN.
module serial_run_tx
  import serial_run_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned RUN_LEN = DEF_RUN_LEN
) (
  input logic            clk,
  input logic            rst,
  serial_run_tx_if.slave bus
);

  localparam int unsigned REM_W = $clog2(WIDTH);
  localparam int unsigned CNT_W = $clog2(RUN_LEN + 1);
  localparam logic [CNT_W-1:0] STUFF_AT = CNT_W'(RUN_LEN - 1);

`ifdef SERIAL_RUN_TX_STUFF_EN
  localparam bit STUFF_EN = 1'b1;
`else
  localparam bit STUFF_EN = 1'b0;
`endif

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [REM_W-1:0] rem_q, rem_d;
  logic             a_q, a_d;
  logic             a_valid_q, a_valid_d;
  logic             stuffed_q, stuffed_d;
  logic             stuff_pending, last_bit, accept, run_flag;
  logic [CNT_W-1:0] run_cnt;

  // Only data bits trigger stuffing; run_cnt describes the bit currently on a.
  assign stuff_pending = STUFF_EN && (state_q == SHIFT) && (run_cnt == STUFF_AT);
  assign last_bit      = (state_q != IDLE) && (rem_q == '0) && !stuff_pending;
  assign bus.din_ready = rst && ((state_q == IDLE) || last_bit);
  assign accept        = bus.din_valid && bus.din_ready;

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    rem_d     = rem_q;
    a_d       = a_q;
    a_valid_d = a_valid_q;
    stuffed_d = 1'b0;
    if (stuff_pending) begin
      state_d   = STUFF;
      a_d       = ~a_q;
      a_valid_d = 1'b1;
      stuffed_d = 1'b1;
    end else if ((state_q != IDLE) && (rem_q != '0)) begin
      state_d   = SHIFT;
      a_d       = shreg_q[WIDTH-1];
      shreg_d   = {shreg_q[WIDTH-2:0], 1'b0};
      rem_d     = rem_q - REM_W'(1);
      a_valid_d = 1'b1;
    end else if (accept) begin
      state_d   = SHIFT;
      a_d       = bus.din[WIDTH-1];
      shreg_d   = {bus.din[WIDTH-2:0], 1'b0};
      rem_d     = REM_W'(WIDTH - 1);
      a_valid_d = 1'b1;
    end else begin
      state_d   = IDLE;
      a_d       = 1'b0;
      a_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      rem_q     <= '0;
      a_q       <= 1'b0;
      a_valid_q <= 1'b0;
      stuffed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      rem_q     <= rem_d;
      a_q       <= a_d;
      a_valid_q <= a_valid_d;
      stuffed_q <= stuffed_d;
    end
  end

  // Fed the next-cycle bit so its registered flag lines up with a_q.
  serial_run_tracker #(.RUN_LEN(RUN_LEN)) u_tracker (
    .clk      (clk),
    .rst      (rst),
    .bit_valid(a_valid_d),
    .bit_in   (a_d),
    .run_flag (run_flag),
    .run_cnt  (run_cnt)
  );

  assign bus.a        = a_q;
  assign bus.a_valid  = a_valid_q;
  assign bus.run_flag = run_flag;
  assign bus.stuffed  = STUFF_EN ? stuffed_q : 1'b0;

endmodule

// File: doc/serial_run_tx.md
# serial_run_tx

Parallel-to-serial transmitter that produces the single-bit stream consumed by the team's Mealy run detector (the 000/111 detector). It accepts WIDTH-bit words over a valid/ready handshake and shifts them out MSB first, one bit per clock. It also flags every bit that completes a run of RUN_LEN equal bits, so the flag matches what the downstream detector's y must show. Optionally it bit-stuffs so the detector never fires.

## Interface
Parameters:
- WIDTH, 8, data word width (>= 2)
- RUN_LEN, 3, run length tracked and flagged (>= 2)

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous, active-low reset (one clock; reset is synchronous and active-low)
- din  input  WIDTH  word to transmit
- din_valid  input  1  din is presented
- din_ready  output  1  block can accept din this cycle
- a  output  1  serial data bit
- a_valid  output  1  a carries a transmitted bit this cycle
- run_flag  output  1  a is the RUN_LEN-th (or later) consecutive equal valid bit
- stuffed  output  1  a is a stuff bit, not data

## Operation
- Reset values: a=0, a_valid=0, run_flag=0, stuffed=0, state IDLE, run history cleared. din_ready=0 while rst=0.
- States: IDLE, SHIFT, STUFF (STUFF exists only with the stuffing macro).
- Accept on a rising edge with din_valid & din_ready. Load the shift register and go to SHIFT.
- SHIFT: outputs are registered. a steps through din[WIDTH-1] down to din[0], one bit per cycle, with a_valid=1.
- din_ready=1 in IDLE. It is also 1 in the cycle that carries the final serial bit of a word, whether that is a data bit or a trailing stuff bit, provided no stuff bit is pending after it. This lets back-to-back words form a gapless stream. If there is no accept, the next state is IDLE.
- Run tracker: holds last_bit and run_cnt, saturating at RUN_LEN.
  - On each valid bit: run_cnt=1 if the bit differs from last_bit or the previous cycle had a_valid=0, otherwise run_cnt+1.
  - run_flag=1 when the updated run_cnt >= RUN_LEN. Runs overlap, so 1111 flags the 3rd and 4th bits.
  - History is kept across back-to-back words and cleared by any a_valid=0 cycle or by reset.
- Reset mid-word: the word is abandoned and not resumed. The next accept starts with a clean run history.
- din and din_valid are ignored when din_ready=0.

## Timing
- Latency: the first bit of a word appears on a in the cycle after the accept edge.
- A word takes WIDTH cycles, plus one per stuff bit.
- Throughput: one bit per clock with back-to-back words, with no idle cycle between them.
- run_flag and stuffed are aligned with the a bit they describe.

## Configuration
- SERIAL_RUN_TX_STUFF_EN defined:
  - After any valid bit that brings run_cnt to RUN_LEN-1, the next cycle emits the complement of that bit, with stuffed=1 and a_valid=1.
  - The stuff bit restarts the run at length 1. This applies after a word's last data bit too.
  - As a result, run_flag never asserts.
- Undefined: no STUFF state, stuffed tied to 0, and data goes out unmodified.

## Structure
- Package serial_run_pkg holds:
  - the state enum (IDLE, SHIFT, STUFF)
  - default WIDTH and RUN_LEN constants
  - a RUN_CNT_W constant, $clog2(RUN_LEN+1)
- Sub-module serial_run_tracker holds last_bit, run_cnt and the run_flag logic. It is reused by the detector's scoreboard.

## Test plan
Default WIDTH=8, RUN_LEN=3, stuffing off unless stated.
- Reset: rst=0 for 2 cycles with din_valid=1, din=8'hFF -> a_valid=0, a=0, run_flag=0, din_ready=0, no accept. After release, din_ready=1.
- Single word 8'b1000_1110 -> a = 1,0,0,0,1,1,1,0 on cycles 1-8. run_flag=1 on cycles 4 and 7 only. Then IDLE, a_valid=0.
- Back-to-back 8'hFF then 8'h00 -> 16 contiguous valid bits. run_flag on bits 3-8 and 11-16. din_ready=1 on bit 8 and the second word is accepted there.
- Gap break: 8'h03, din_valid held low 2 cycles, then 8'hC0 -> the first two bits of the second word do not assert run_flag. Back-to-back, bit 1 of the second word would flag.
- Stuffing (SERIAL_RUN_TX_STUFF_EN), din=8'hFF -> 12 cycles: 1,1,0,1,1,0,1,1,0,1,1,0. stuffed=1 on cycles 3, 6, 9 and 12. run_flag never asserts. din_ready=1 on cycle 12.
- Reset mid-word: rst=0 during bit 4 of 8'hAA -> a_valid=0 next cycle. A new word 8'hE0 then flags its 3rd bit with no carry-over from the aborted word.
